tt_um_lif_neuron_array: RTL and testbench
=========================================

TT_UM_LIF_NEURON_ARRAY -- requirements
Module: tt_um_lif_neuron_array

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4, range 1..8: number of neurons.
REQ-002 SHALL have parameter MEM_WIDTH, default 8: signed membrane-potential and threshold width.
REQ-003 SHALL have parameter LEAK_SHIFT, default 2: per-cycle leak, v -= v>>>LEAK_SHIFT.
REQ-004 SHALL have parameter REFRACT_CYCLES, default 3: post-spike dead time in cycles.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port ena  in  1  enable; 0 freezes the design.
REQ-008 SHALL have port ui_in  in  8  spike inputs x[7:0], shared by all neurons.
REQ-009 SHALL have port uo_out  out  8  bit n = registered spike of neuron n (n<NUM_NEURONS), upper bits 0.
REQ-010 SHALL have port uio_in  in  8  [7] cfg_we, [6] cfg_restart, [5] mode (0 perceptron, 1 LIF), [4] unused, [3:0] cfg nibble.
REQ-011 SHALL have port uio_out  out  8  [4] cfg_ready, all other bits 0.
REQ-012 SHALL have port uio_oe  out  8  constant 8'b0001_0000.

Function
REQ-013 Weights SHALL be 4-bit signed (-8..+7), one per (neuron, input); one shared signed threshold TH of MEM_WIDTH bits.
REQ-014 Synaptic sum S_n = sum over i of w[n][i] where x[i]=1; SHALL be computed at MEM_WIDTH+2 bits with no overflow.
REQ-015 Perceptron mode: spike_n SHALL register (S_n >= TH) each enabled cycle; membranes held at 0.
REQ-016 LIF mode: v_next = v - (v>>>LEAK_SHIFT) + S_n, SHALL saturate to the signed MEM_WIDTH range, never wrap.
REQ-017 LIF: if refractory counter rc_n = 0 and v_next >= TH: spike_n <= 1, v <= 0, rc_n <= REFRACT_CYCLES.
REQ-018 LIF: if rc_n != 0: spike_n <= 0, v held at 0, inputs ignored, rc_n decrements; integration resumes on the edge where rc_n = 0.
REQ-019 Latency SHALL be 1 cycle: ui_in sampled at edge k drives uo_out after edge k.
REQ-020 Mode SHALL be sampled every cycle; switching to perceptron clears v and rc on that edge.
REQ-021 ena=0: v, rc, weights, TH, config FSM SHALL hold; spike registers SHALL clear to 0.
REQ-022 Config FSM states: READY, LOADING; cfg_ready = (state == READY).
REQ-023 cfg_restart=1 (any state) SHALL: pointer <= 0, state <= LOADING, all v/rc/spikes <= 0.
REQ-024 LOADING, cfg_we=1: nibble stored at pointer, pointer++; order TH[3:0], TH[7:4] (further TH nibbles if MEM_WIDTH>8), then w[0][0..7], w[1][0..7], ...
REQ-025 Writing the last nibble SHALL move LOADING -> READY on the same edge.
REQ-026 Neurons SHALL not integrate or spike while LOADING; outputs held 0.
REQ-027 cfg_we in READY SHALL be ignored; cfg_restart and cfg_we together: restart wins, nibble discarded.

Reset
REQ-028 rst_n=0 at an edge SHALL set: state READY, all weights +1, TH = 1, v = 0, rc = 0, pointer = 0, uo_out = 0; overrides ena and config activity, including mid-load.

Structure
REQ-029 Shared package neuron_pkg SHALL hold parameter defaults, weight width (4), mode and config-state enums, and function computing nibble count = MEM_WIDTH/4 + 8*NUM_NEURONS.
REQ-030 One sub-module lif_neuron_core (sum, leak, saturate, threshold, refractory for one neuron) SHALL be instantiated NUM_NEURONS times; config FSM and weight store in top.

Verification
REQ-031 After reset, perceptron mode: ui_in=8'h11 -> uo_out[3:0]=4'hF next cycle; ui_in=8'h00 -> 4'h0.
REQ-032 LIF, TH=20, w[0][*]=+3: ui_in=8'h01 held -> v0 = 3,6,8,9,10,11,12,12..., uo_out[0] never 1.
REQ-033 Same config, ui_in=8'hFF -> uo_out[0] pattern 1,0,0,0,1,0,0,0 (period REFRACT_CYCLES+1).
REQ-034 LIF, w[0][*]=-8, ui_in=8'hFF -> v0 = -64,-112,-128,-128 (probe), no wrap, no spike.
REQ-035 cfg_restart mid-load, then 2 nibbles, rst_n=0 -> cfg_ready=1, defaults restored, REQ-031 passes.
REQ-036 ena=0 for 5 cycles mid-integration -> uo_out=0, v0 unchanged; ena=1 resumes sequence exactly.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the LIF neuron array: parameter defaults, weight
// geometry, mode / config-state encodings and the config stream length.
package neuron_pkg;

  localparam int DEF_NUM_NEURONS    = 4;
  localparam int DEF_MEM_WIDTH      = 8;
  localparam int DEF_LEAK_SHIFT     = 2;
  localparam int DEF_REFRACT_CYCLES = 3;

  localparam int WEIGHT_WIDTH = 4;
  localparam int NUM_INPUTS   = 8;

  typedef enum logic {
    MODE_PERCEPTRON = 1'b0,
    MODE_LIF        = 1'b1
  } mode_t;

  typedef enum logic {
    CFG_READY   = 1'b0,
    CFG_LOADING = 1'b1
  } cfg_state_t;

  // Length of the config nibble stream: threshold nibbles, then one nibble
  // per (neuron, input) weight.
  function automatic int cfg_nibble_count(input int mem_width, input int num_neurons);
    return mem_width / 4 + NUM_INPUTS * num_neurons;
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One neuron: synaptic sum, leak, saturating integration, threshold compare
// and refractory counting. Weights and threshold come from the top's store.
module lif_neuron_core
  import neuron_pkg::*;
#(
  parameter int MEM_WIDTH      = DEF_MEM_WIDTH,
  parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ena,
  input  logic                                 clear,
  input  mode_t                                mode,
  input  logic [NUM_INPUTS-1:0]                x,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]   weights,
  input  logic signed [MEM_WIDTH-1:0]          th,
  output logic                                 spike,
  output logic signed [MEM_WIDTH-1:0]          v
);

  // Sum is wide enough for eight worst-case weights; the integration path
  // gets one more bit so v - leak + sum can never wrap before saturation.
  localparam int SUM_W = MEM_WIDTH + 2;
  localparam int EXT_W = MEM_WIDTH + 3;
  localparam int RC_W  = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic signed [EXT_W-1:0] V_MAX = EXT_W'((2 ** (MEM_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] V_MIN = EXT_W'(-(2 ** (MEM_WIDTH - 1)));

  logic [RC_W-1:0]                rc;
  logic signed [SUM_W-1:0]        sum;
  logic signed [WEIGHT_WIDTH-1:0] w_i;
  logic signed [EXT_W-1:0]        raw;
  logic signed [EXT_W-1:0]        raw_sat;
  logic signed [MEM_WIDTH-1:0]    v_next;
  logic                           fire_perc;
  logic                           fire_lif;

  // Synaptic sum over active inputs, sign-extending each 4-bit weight.
  always_comb begin
    sum = '0;
    w_i = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_i = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      if (x[i]) sum = sum + SUM_W'(w_i);
    end
  end

  // Leaky integration with saturation to the signed membrane range.
  always_comb begin
    raw     = EXT_W'(v) - EXT_W'(v >>> LEAK_SHIFT) + EXT_W'(sum);
    raw_sat = raw;
    if (raw > V_MAX) raw_sat = V_MAX;
    if (raw < V_MIN) raw_sat = V_MIN;
    v_next    = raw_sat[MEM_WIDTH-1:0];
    fire_perc = (sum >= SUM_W'(th));
    fire_lif  = (v_next >= th);
  end

  // Membrane, refractory counter and registered spike.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v     <= '0;
      rc    <= '0;
      spike <= 1'b0;
    end else if (!ena) begin
      spike <= 1'b0;
    end else if (clear) begin
      v     <= '0;
      rc    <= '0;
      spike <= 1'b0;
    end else if (mode == MODE_PERCEPTRON) begin
      v     <= '0;
      rc    <= '0;
      spike <= fire_perc;
    end else if (rc != '0) begin
      v     <= '0;
      rc    <= rc - RC_W'(1);
      spike <= 1'b0;
    end else if (fire_lif) begin
      v     <= '0;
      rc    <= RC_W'(REFRACT_CYCLES);
      spike <= 1'b1;
    end else begin
      v     <= v_next;
      spike <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_um_lif_neuron_array.sv
// Array of LIF / perceptron neurons sharing 8 spike inputs, with a nibble
// serial config loader for the shared threshold and per-neuron weights.
module tt_um_lif_neuron_array
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS    = DEF_NUM_NEURONS,
  parameter int MEM_WIDTH      = DEF_MEM_WIDTH,
  parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int TH_NIBBLES    = MEM_WIDTH / 4;
  localparam int NUM_WEIGHTS   = NUM_NEURONS * NUM_INPUTS;
  localparam int TOTAL_NIBBLES = cfg_nibble_count(MEM_WIDTH, NUM_NEURONS);
  localparam int PTR_W         = $clog2(TOTAL_NIBBLES + 1);
  localparam int ROW_W         = NUM_INPUTS * WEIGHT_WIDTH;

  // Config handshake: cfg_we is a one-cycle write strobe that is accepted
  // only while LOADING (cfg_ready low); each accepted strobe consumes the
  // nibble on uio_in[3:0]. cfg_restart takes priority over cfg_we.
  logic                        cfg_we;
  logic                        cfg_restart;
  mode_t                       mode;
  logic [3:0]                  nibble;
  logic                        unused_cfg_bit;

  cfg_state_t                  cfg_state;
  cfg_state_t                  cfg_state_next;
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            ptr_next;
  logic                        wr_en;
  logic                        neuron_clear;

  logic signed [MEM_WIDTH-1:0] th;
  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] w_flat;
  logic [NUM_NEURONS-1:0]      spikes;
  logic [NUM_NEURONS*MEM_WIDTH-1:0] v_flat;

  assign cfg_we         = uio_in[7];
  assign cfg_restart    = uio_in[6];
  assign mode           = mode_t'(uio_in[5]);
  assign unused_cfg_bit = uio_in[4];
  assign nibble         = uio_in[3:0];

  // Config FSM state register; everything holds while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_state <= CFG_READY;
      ptr       <= '0;
    end else if (ena) begin
      cfg_state <= cfg_state_next;
      ptr       <= ptr_next;
    end
  end

  // Config FSM next state: restart wins, writes only count while LOADING.
  always_comb begin
    cfg_state_next = cfg_state;
    ptr_next       = ptr;
    wr_en          = 1'b0;
    if (cfg_restart) begin
      cfg_state_next = CFG_LOADING;
      ptr_next       = '0;
    end else if (cfg_state == CFG_LOADING && cfg_we) begin
      wr_en = 1'b1;
      if (ptr == PTR_W'(TOTAL_NIBBLES - 1)) begin
        cfg_state_next = CFG_READY;
        ptr_next       = '0;
      end else begin
        ptr_next = ptr + PTR_W'(1);
      end
    end
  end

  // Threshold and weight store, written one nibble at a time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      th     <= MEM_WIDTH'(1);
      w_flat <= {NUM_WEIGHTS{WEIGHT_WIDTH'(1)}};
    end else if (ena && wr_en) begin
      for (int k = 0; k < TH_NIBBLES; k++) begin
        if (int'(ptr) == k) th[k*4 +: 4] <= nibble;
      end
      for (int k = 0; k < NUM_WEIGHTS; k++) begin
        if (int'(ptr) == TH_NIBBLES + k) w_flat[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= nibble;
      end
    end
  end

  // Neurons sit cleared while a restart is requested or a load is running.
  assign neuron_clear = cfg_restart | (cfg_state == CFG_LOADING);

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    lif_neuron_core #(
      .MEM_WIDTH      (MEM_WIDTH),
      .LEAK_SHIFT     (LEAK_SHIFT),
      .REFRACT_CYCLES (REFRACT_CYCLES)
    ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .clear   (neuron_clear),
      .mode    (mode),
      .x       (ui_in),
      .weights (w_flat[n*ROW_W +: ROW_W]),
      .th      (th),
      .spike   (spikes[n]),
      .v       (v_flat[n*MEM_WIDTH +: MEM_WIDTH])
    );
  end

  assign uo_out  = 8'(spikes);
  assign uio_out = {3'b000, (cfg_state == CFG_READY), 4'b0000};
  assign uio_oe  = 8'b0001_0000;

endmodule

// File: tb/tb_tt_um_lif_neuron_array.sv
// Bench for tt_um_lif_neuron_array: directed scenarios plus a randomized run
// against an integer behavioural model of the neuron array and loader.
module tb_tt_um_lif_neuron_array;

  localparam int NUM = 4;
  localparam int MW  = 8;
  localparam int LS  = 2;
  localparam int RC  = 3;
  localparam int THN = MW / 4;
  localparam int TOTAL = THN + 8 * NUM;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_lif_neuron_array #(
    .NUM_NEURONS(NUM), .MEM_WIDTH(MW), .LEAK_SHIFT(LS), .REFRACT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  logic signed [MW-1:0] v0;
  assign v0 = dut.v_flat[MW-1:0];

  int n_checks = 0;
  int n_fail   = 0;
  logic cur_mode = 1'b0;

  // ---------------- reference model ----------------
  int         m_v[NUM];
  int         m_rc[NUM];
  int         m_w[NUM][8];
  logic [MW-1:0] m_th_bits;
  bit         m_ready;
  int         m_ptr;
  logic [7:0] m_spk;

  function automatic int nib_to_int(input logic [3:0] nib);
    return (nib >= 4'd8) ? int'(nib) - 16 : int'(nib);
  endfunction

  function automatic void model_step(input logic [7:0] ui_v, input logic [7:0] uio_v,
                                     input logic ena_v, input logic rst_v);
    int th, s, vn, lo, hi;
    lo = -(2 ** (MW - 1));
    hi = (2 ** (MW - 1)) - 1;
    if (!rst_v) begin
      for (int n = 0; n < NUM; n++) begin
        m_v[n] = 0; m_rc[n] = 0;
        for (int i = 0; i < 8; i++) m_w[n][i] = 1;
      end
      m_th_bits = MW'(1); m_ready = 1'b1; m_ptr = 0; m_spk = 8'h00;
      return;
    end
    if (!ena_v) begin
      m_spk = 8'h00;
      return;
    end
    th = int'($signed(m_th_bits));
    for (int n = 0; n < NUM; n++) begin
      if (uio_v[6] || !m_ready) begin
        m_v[n] = 0; m_rc[n] = 0; m_spk[n] = 1'b0;
      end else begin
        s = 0;
        for (int i = 0; i < 8; i++) if (ui_v[i]) s += m_w[n][i];
        if (!uio_v[5]) begin
          m_spk[n] = (s >= th); m_v[n] = 0; m_rc[n] = 0;
        end else if (m_rc[n] > 0) begin
          m_spk[n] = 1'b0; m_v[n] = 0; m_rc[n]--;
        end else begin
          vn = m_v[n] - (m_v[n] >>> LS) + s;
          if (vn > hi) vn = hi;
          if (vn < lo) vn = lo;
          if (vn >= th) begin
            m_spk[n] = 1'b1; m_v[n] = 0; m_rc[n] = RC;
          end else begin
            m_spk[n] = 1'b0; m_v[n] = vn;
          end
        end
      end
    end
    if (uio_v[6]) begin
      m_ready = 1'b0; m_ptr = 0;
    end else if (!m_ready && uio_v[7]) begin
      if (m_ptr < THN) m_th_bits[m_ptr*4 +: 4] = uio_v[3:0];
      else m_w[(m_ptr - THN) / 8][(m_ptr - THN) % 8] = nib_to_int(uio_v[3:0]);
      m_ptr++;
      if (m_ptr == TOTAL) begin
        m_ready = 1'b1; m_ptr = 0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] ui_v, input logic [7:0] uio_v,
                      input logic ena_v, input logic rst_v);
    ui_in = ui_v; uio_in = uio_v; ena = ena_v; rst_n = rst_v;
    @(posedge clk);
    model_step(ui_v, uio_v, ena_v, rst_v);
    #1;
  endtask

  function automatic logic [7:0] cfg_word(input logic we, input logic restart,
                                          input logic [3:0] nib);
    return {we, restart, cur_mode, 1'b0, nib};
  endfunction

  // Restart then stream TH and all weights; neuron 0 gets w0 unless rand_w.
  task automatic load_cfg(input logic [7:0] th_v, input logic [3:0] w0, input bit rand_w);
    logic [3:0] nib;
    step(8'($urandom), cfg_word(1'b0, 1'b1, 4'h0), 1'b1, 1'b1);
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++; $display("FAIL load_busy: uio_out=%h expected 00", uio_out);
    end
    for (int k = 0; k < TOTAL; k++) begin
      if (k < THN) nib = th_v[k*4 +: 4];
      else if (!rand_w && k < THN + 8) nib = w0;
      else nib = 4'($urandom);
      step(8'($urandom), cfg_word(1'b1, 1'b0, nib), 1'b1, 1'b1);
    end
    n_checks++;
    if (uio_out !== 8'h10 || uo_out !== 8'h00) begin
      n_fail++; $display("FAIL load_done: uio_out=%h uo_out=%h expected 10/00", uio_out, uo_out);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(8'hFF, 8'hC5, 1'b1, 1'b0);
    step(8'hFF, 8'hC5, 1'b1, 1'b0);
    n_checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h10 || uio_oe !== 8'h10 || v0 !== 8'sd0) begin
      n_fail++;
      $display("FAIL reset: uo=%h uio_out=%h oe=%h v0=%0d expected 00/10/10/0", uo_out, uio_out, uio_oe, v0);
    end
  endtask

  task automatic test_perceptron_defaults();
    cur_mode = 1'b0;
    step(8'h11, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== 8'h0F) begin
      n_fail++; $display("FAIL perc_11: uo_out=%h expected 0f", uo_out);
    end
    step(8'h00, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL perc_00: uo_out=%h expected 00", uo_out);
    end
  endtask

  task automatic test_lif_leak();
    int exp_v[10] = '{3, 6, 8, 9, 10, 11, 12, 12, 12, 12};
    cur_mode = 1'b1;
    load_cfg(8'd20, 4'h3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(8'h01, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
      n_checks++;
      if (v0 !== 8'(exp_v[k]) || uo_out[0] !== 1'b0) begin
        n_fail++; $display("FAIL lif_leak[%0d]: v0=%0d spike=%b expected %0d/0", k, v0, uo_out[0], exp_v[k]);
      end
    end
  endtask

  task automatic test_refractory();
    logic exp_s[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    cur_mode = 1'b0;
    step(8'h00, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
    cur_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(8'hFF, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
      n_checks++;
      if (uo_out[0] !== exp_s[k]) begin
        n_fail++; $display("FAIL refract[%0d]: spike=%b expected %b", k, uo_out[0], exp_s[k]);
      end
    end
  endtask

  task automatic test_saturate();
    int exp_v[4] = '{-64, -112, -128, -128};
    cur_mode = 1'b1;
    load_cfg(8'd20, 4'h8, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(8'hFF, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
      n_checks++;
      if (v0 !== 8'(exp_v[k]) || uo_out[0] !== 1'b0) begin
        n_fail++; $display("FAIL saturate[%0d]: v0=%0d spike=%b expected %0d/0", k, v0, uo_out[0], exp_v[k]);
      end
    end
  endtask

  task automatic test_ena_freeze();
    int exp_v[7] = '{3, 6, 8, 9, 10, 11, 12};
    cur_mode = 1'b1;
    load_cfg(8'd20, 4'h3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(8'h01, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
      n_checks++;
      if (v0 !== 8'(exp_v[k])) begin
        n_fail++; $display("FAIL ena_pre[%0d]: v0=%0d expected %0d", k, v0, exp_v[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(8'hFF, cfg_word(1'b1, 1'b1, 4'h7), 1'b0, 1'b1);
      n_checks++;
      if (v0 !== 8'sd8 || uo_out !== 8'h00 || uio_out !== 8'h10) begin
        n_fail++; $display("FAIL ena_hold[%0d]: v0=%0d uo=%h uio=%h expected 8/00/10", k, v0, uo_out, uio_out);
      end
    end
    for (int k = 3; k < 7; k++) begin
      step(8'h01, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
      n_checks++;
      if (v0 !== 8'(exp_v[k]) || uo_out[0] !== 1'b0) begin
        n_fail++; $display("FAIL ena_resume[%0d]: v0=%0d expected %0d", k, v0, exp_v[k]);
      end
    end
  endtask

  task automatic test_restart_midload();
    cur_mode = 1'b0;
    step(8'h00, cfg_word(1'b0, 1'b1, 4'h0), 1'b1, 1'b1);
    step(8'h00, cfg_word(1'b1, 1'b0, 4'hF), 1'b1, 1'b1);
    step(8'h00, cfg_word(1'b1, 1'b0, 4'h7), 1'b1, 1'b1);
    n_checks++;
    if (uio_out !== 8'h00) begin
      n_fail++; $display("FAIL midload_busy: uio_out=%h expected 00", uio_out);
    end
    step(8'h11, cfg_word(1'b1, 1'b0, 4'h3), 1'b1, 1'b0);
    n_checks++;
    if (uio_out !== 8'h10 || uo_out !== 8'h00) begin
      n_fail++; $display("FAIL midload_reset: uio_out=%h uo=%h expected 10/00", uio_out, uo_out);
    end
    step(8'h11, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== 8'h0F) begin
      n_fail++; $display("FAIL midload_perc_11: uo_out=%h expected 0f", uo_out);
    end
    step(8'h00, cfg_word(1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL midload_perc_00: uo_out=%h expected 00", uo_out);
    end
  endtask

  task automatic test_random();
    logic ena_v, rst_v, we, restart;
    cur_mode = 1'b1;
    load_cfg(8'($urandom_range(1, 30)), 4'h0, 1'b1);
    for (int k = 0; k < 600; k++) begin
      ena_v   = ($urandom_range(0, 9) != 0);
      rst_v   = ($urandom_range(0, 299) != 0);
      restart = ($urandom_range(0, 79) == 0);
      we      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) cur_mode = ~cur_mode;
      step(8'($urandom), cfg_word(we, restart, 4'($urandom)), ena_v, rst_v);
      n_checks++;
      if (uo_out !== m_spk || uio_out !== {3'b000, m_ready, 4'b0000} || v0 !== 8'(m_v[0])) begin
        n_fail++;
        $display("FAIL random[%0d]: uo=%h uio=%h v0=%0d expected %h/%h/%0d",
                 k, uo_out, uio_out, v0, m_spk, {3'b000, m_ready, 4'b0000}, m_v[0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_perceptron_defaults();
    test_lif_leak();
    test_refractory();
    test_saturate();
    test_ena_freeze();
    test_restart_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
